// File: rtl/multdiv_if.sv
// ============================================================================
// Module   : multdiv_if
// Brief    : Operand/control/result bundle between the E stage and multdiv_unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface multdiv_if;
    logic        start;
    logic        MTWrite;
    logic [3:0]  MULTDIVControl;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        occupied;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output start, MTWrite, MULTDIVControl, A, B,
        input  busy, occupied, HI, LO
    );

    modport slave (
        input  start, MTWrite, MULTDIVControl, A, B,
        output busy, occupied, HI, LO
    );
endinterface

`default_nettype wire

// File: rtl/multdiv_unit.sv
// ============================================================================
// Module   : multdiv_unit
// Brief    : Multi-cycle MIPS mult/div unit holding the architectural HI/LO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multdiv_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic     clk,
    input  logic     reset,
    multdiv_if.slave bus
);

    localparam int c_MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW           = $clog2(c_MAX_CYCLES) + 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MTHI  = 4'd4;
    localparam logic [3:0] OP_MTLO  = 4'd5;

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic [31:0]   hi_tmp_q, hi_tmp_d, lo_tmp_q, lo_tmp_d;

    logic [63:0]   w_prod_s, w_prod_u;
    logic [31:0]   w_quot_s, w_rem_s, w_quot_u, w_rem_u;
    logic          w_div_ovf, w_div_zero;

    assign w_prod_s   = $signed({{32{bus.A[31]}}, bus.A}) * $signed({{32{bus.B[31]}}, bus.B});
    assign w_prod_u   = {32'b0, bus.A} * {32'b0, bus.B};
    assign w_div_zero = (bus.B == 32'd0);
    // The single overflowing signed quotient is pinned explicitly rather than left to the divider.
    assign w_div_ovf  = (bus.A == 32'h8000_0000) && (bus.B == 32'hFFFF_FFFF);
    assign w_quot_s   = w_div_ovf ? 32'h8000_0000 : 32'($signed(bus.A) / $signed(bus.B));
    assign w_rem_s    = w_div_ovf ? 32'd0         : 32'($signed(bus.A) % $signed(bus.B));
    assign w_quot_u   = bus.A / bus.B;
    assign w_rem_u    = bus.A % bus.B;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            hi_tmp_q <= '0;
            lo_tmp_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            hi_tmp_q <= hi_tmp_d;
            lo_tmp_q <= lo_tmp_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        hi_tmp_d = hi_tmp_q;
        lo_tmp_d = lo_tmp_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_RUN;
                    // Divide-by-zero pends the current HI/LO, so the commit is a no-op.
                    case (bus.MULTDIVControl)
                        OP_MULT: begin
                            cnt_d    = CW'(MULT_CYCLES);
                            hi_tmp_d = w_prod_s[63:32];
                            lo_tmp_d = w_prod_s[31:0];
                        end
                        OP_MULTU: begin
                            cnt_d    = CW'(MULT_CYCLES);
                            hi_tmp_d = w_prod_u[63:32];
                            lo_tmp_d = w_prod_u[31:0];
                        end
                        OP_DIV: begin
                            cnt_d    = CW'(DIV_CYCLES);
                            hi_tmp_d = w_div_zero ? hi_q : w_rem_s;
                            lo_tmp_d = w_div_zero ? lo_q : w_quot_s;
                        end
                        OP_DIVU: begin
                            cnt_d    = CW'(DIV_CYCLES);
                            hi_tmp_d = w_div_zero ? hi_q : w_rem_u;
                            lo_tmp_d = w_div_zero ? lo_q : w_quot_u;
                        end
                        default: begin
                            cnt_d    = CW'(DIV_CYCLES);
                            hi_tmp_d = hi_q;
                            lo_tmp_d = lo_q;
                        end
                    endcase
                end else if (bus.MTWrite) begin
                    if (bus.MULTDIVControl == OP_MTHI) begin
                        hi_d = bus.A;
                    end else if (bus.MULTDIVControl == OP_MTLO) begin
                        lo_d = bus.A;
                    end
                end
            end
            S_RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    hi_d    = hi_tmp_q;
                    lo_d    = lo_tmp_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy     = (state_q == S_RUN);
        bus.occupied = bus.start | (state_q == S_RUN);
        bus.HI       = hi_q;
        bus.LO       = lo_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_multdiv_unit.sv
// ============================================================================
// Module   : tb_multdiv_unit
// Brief    : Directed self-checking bench for multdiv_unit against a cycle model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multdiv_unit;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;
    bit   cmp_en;

    multdiv_if mif ();

    multdiv_unit #(
        .MULT_CYCLES(MULT_N),
        .DIV_CYCLES (DIV_N)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (mif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: committed HI/LO plus cycles left on the pending op.
    logic [31:0] m_hi, m_lo;
    logic [63:0] m_res;
    int          pending;

    function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [31:0] hi,
                                               input logic [31:0] lo);
        longint      sa, sb, q, r;
        logic [63:0] ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            4'd0: begin p = 64'(sa * sb); return p; end
            4'd1: return ua * ub;
            4'd2: begin
                if (b == 32'd0) return {hi, lo};
                q = sa / sb;
                r = sa % sb;
                return {32'(r), 32'(q)};
            end
            4'd3: begin
                if (b == 32'd0) return {hi, lo};
                return {a % b, a / b};
            end
            default: return {hi, lo};
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_hi = '0; m_lo = '0; pending = 0;
        end else if (pending > 0) begin
            pending = pending - 1;
            if (pending == 0) begin
                m_hi = m_res[63:32];
                m_lo = m_res[31:0];
            end
        end else if (mif.start) begin
            m_res   = ref_result(mif.MULTDIVControl, mif.A, mif.B, m_hi, m_lo);
            pending = (mif.MULTDIVControl < 4'd2) ? MULT_N : DIV_N;
        end else if (mif.MTWrite) begin
            if (mif.MULTDIVControl == 4'd4) m_hi = mif.A;
            if (mif.MULTDIVControl == 4'd5) m_lo = mif.A;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model busy", 32'(mif.busy), 32'(pending != 0));
            check("model occupied", 32'(mif.occupied), 32'(mif.start | (pending != 0)));
            check("model HI", mif.HI, m_hi);
            check("model LO", mif.LO, m_lo);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string nm, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int n_exp,
                          input logic [31:0] prev_hi, input logic [31:0] prev_lo,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int cyc;
        mif.start = 1'b1;
        mif.MULTDIVControl = op;
        mif.A = a;
        mif.B = b;
        tick();
        mif.start = 1'b0;
        check({nm, " hold HI"}, mif.HI, prev_hi);
        check({nm, " hold LO"}, mif.LO, prev_lo);
        cyc = 0;
        while (mif.busy === 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        check({nm, " busy cycles"}, 32'(cyc), 32'(n_exp));
        check({nm, " HI"}, mif.HI, exp_hi);
        check({nm, " LO"}, mif.LO, exp_lo);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        cmp_en = 1'b0;
        reset = 1'b1;
        mif.start = 1'b0;
        mif.MTWrite = 1'b0;
        mif.MULTDIVControl = 4'd0;
        mif.A = '0;
        mif.B = '0;

        tick();
        cmp_en = 1'b1;
        tick();
        reset = 1'b0;
        check("reset HI", mif.HI, 32'h0);
        check("reset LO", mif.LO, 32'h0);
        check("reset busy", 32'(mif.busy), 32'h0);
        check("reset occupied", 32'(mif.occupied), 32'h0);

        run_op("MULT", 4'd0, 32'hFFFF_FFFE, 32'd3, MULT_N,
               32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("MULTU", 4'd1, 32'hFFFF_FFFE, 32'd3, MULT_N,
               32'hFFFF_FFFF, 32'hFFFF_FFFA, 32'h0000_0002, 32'hFFFF_FFFA);
        run_op("DIV", 4'd2, 32'hFFFF_FFF9, 32'd2, DIV_N,
               32'h0000_0002, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        mif.MTWrite = 1'b1;
        mif.MULTDIVControl = 4'd4;
        mif.A = 32'h11;
        tick();
        check("MTHI HI", mif.HI, 32'h11);
        mif.MULTDIVControl = 4'd5;
        mif.A = 32'h22;
        tick();
        mif.MTWrite = 1'b0;
        check("MTLO LO", mif.LO, 32'h22);
        check("MT busy", 32'(mif.busy), 32'h0);

        run_op("DIVU by zero", 4'd3, 32'd7, 32'd0, DIV_N,
               32'h11, 32'h22, 32'h11, 32'h22);
        run_op("DIV overflow", 4'd2, 32'h8000_0000, 32'hFFFF_FFFF, DIV_N,
               32'h11, 32'h22, 32'h0, 32'h8000_0000);
        run_op("DIVU", 4'd3, 32'd100, 32'd7, DIV_N,
               32'h0, 32'h8000_0000, 32'd2, 32'd14);

        mif.start = 1'b1;
        mif.MULTDIVControl = 4'd0;
        mif.A = 32'd3;
        mif.B = 32'd3;
        tick();
        mif.start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midreset busy", 32'(mif.busy), 32'h0);
        check("midreset HI", mif.HI, 32'h0);
        check("midreset LO", mif.LO, 32'h0);

        run_op("MULT after reset", 4'd0, 32'd4, 32'd5, MULT_N,
               32'h0, 32'h0, 32'h0, 32'd20);

        tick();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/multdiv_unit.md
# multdiv_unit

Execute-stage multiply/divide unit of the five-stage MIPS pipeline. It takes operands and the decoded `MULTDIVControl` / `start` signals for the instruction in E, and runs `mult`, `multu`, `div` and `divu` as multi-cycle operations. It also performs `mthi` / `mtlo` in a single cycle. It holds the architectural HI/LO registers, which are read by `mfhi` / `mflo`. Its `busy` / `occupied` outputs feed the hazard unit, which stalls D-stage multdiv instructions.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy cycles for `mult` / `multu`.
- `DIV_CYCLES`, default 10: busy cycles for `div` / `divu`.

Ports:
- `clk`  in  1  pipeline clock; everything updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  E-stage instruction is `mult`, `multu`, `div` or `divu`.
- `MTWrite`  in  1  E-stage instruction is `mthi` or `mtlo`.
- `MULTDIVControl`  in  4  operation select:
  - 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO.
  - Don't-care when `start` and `MTWrite` are both 0.
- `A`  in  32  forwarded rs value.
- `B`  in  32  forwarded rt value.
- `busy`  out  1  a multi-cycle operation is in flight.
- `occupied`  out  1  combinational `start | busy`, to the hazard unit.
- `HI`  out  32  architectural HI register.
- `LO`  out  32  architectural LO register.

## Operation
- Internal state:
  - `HI`, `LO`: architectural registers.
  - `hi_tmp`, `lo_tmp`: pending result.
  - `cnt`: down-counter, width = clog2(max(MULT_CYCLES, DIV_CYCLES)) + 1.
  - FSM with two states, IDLE and RUN.
- IDLE, `start = 1`:
  - Compute the result from `A` / `B` in the same cycle and latch it into `hi_tmp` / `lo_tmp`.
  - Load `cnt` with MULT_CYCLES for codes 0/1, or DIV_CYCLES for codes 2/3.
  - Move to RUN.
- IDLE, `MTWrite = 1`:
  - Code 4: HI <= A.
  - Code 5: LO <= A.
  - Stay in IDLE.
- IDLE, `start` and `MTWrite` both 1: illegal. `start` wins and the MT write is dropped.
- RUN:
  - `cnt` decrements each cycle.
  - When `cnt == 1`: HI <= hi_tmp, LO <= lo_tmp, return to IDLE.
  - `start` and `MTWrite` are ignored; the hazard unit guarantees they are not asserted.
- `busy` = (state == RUN).
- Arithmetic:
  - MULT: signed 32x32 to 64-bit product; HI = [63:32], LO = [31:0].
  - MULTU: unsigned 32x32 to 64-bit product; HI = [63:32], LO = [31:0].
  - DIV: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - DIV 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0.
  - DIVU: unsigned quotient into LO, unsigned remainder into HI.
- Divide by zero (B == 0): the full busy period still runs, but HI/LO are left unchanged.
- HI/LO outputs always show the committed values. Partial results are never visible.

## Timing
- Reset:
  - Applies on any edge with `reset = 1`, including mid-RUN.
  - Sets state = IDLE, `cnt` = 0, HI = LO = hi_tmp = lo_tmp = 0, `busy` = 0.
  - An in-flight result is discarded.
- Start is sampled at edge E0:
  - `busy` is high for exactly N cycles after E0 (N = MULT_CYCLES or DIV_CYCLES).
  - HI/LO change at edge E0+N; `busy` falls on that same edge.
  - New HI/LO are readable from the cycle after E0+N.
- `occupied` is high in the `start` cycle and in all N busy cycles.
- Back-to-back start:
  - A new `start` is accepted in the cycle right after `busy` falls.
  - No dead cycle is required.
- `mthi` / `mtlo`: single cycle; the value is visible on HI/LO in the next cycle.
- `busy` never glitches high for `MTWrite`.

## Test plan
- Reset: hold `reset` for 2 cycles, then release.
  - HI = LO = 0, `busy` = 0, `occupied` = 0.
- MULT with A = 0xFFFFFFFE (-2), B = 3:
  - `busy` high for exactly 5 cycles.
  - Then HI = 0xFFFFFFFF, LO = 0xFFFFFFFA.
  - During busy, HI/LO keep their previous values.
- MULTU, same operands:
  - HI = 0x00000002, LO = 0xFFFFFFFA after 5 cycles.
- DIV with A = 0xFFFFFFF9 (-7), B = 2:
  - `busy` high for 10 cycles.
  - Then LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- DIVU with A = 7, B = 0, after first seeding with MTHI A = 0x11 and MTLO A = 0x22:
  - The MTHI/MTLO writes are visible one cycle later.
  - `busy` high for 10 cycles.
  - HI stays 0x11 and LO stays 0x22.
- Reset mid-operation: start MULT, assert `reset` in busy cycle 3.
  - Next cycle: `busy` = 0, HI = LO = 0.
  - A MULT started immediately after reset (A = 4, B = 5) finishes with LO = 20 after 5 cycles.
